if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage datapath and IF/ID pipeline register for the 16-bit five-stage pipeline. Owns the PC, drives instruction-memory address, and exports the fetched opcode to the IF control decoder. Consumes that decoder's Jump/Branch/jmp_r to select next PC: J/JAL resolve in IF with zero bubbles, branches are predicted not-taken, and JR/JALR stall fetch until a later stage redirects. Also handles HALT and pipeline stall/flush.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 16'h0800, encoding inserted into IF/ID on bubbles (opcode 00001)

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_addr  out  16  instruction address, equals pc_q combinationally
- imem_rdata  in  16  instruction at imem_addr, valid same cycle (combinational memory)
- fetch_opcode  out  5  imem_rdata[15:11], to IF control decoder
- Jump  in  1  decoder: J/JR/JAL/JALR
- Branch  in  1  decoder: BEQZ/BNEZ/BLTZ/BGEZ (prediction only, not-taken)
- jmp_r  in  1  decoder: register-indirect jump (JR/JALR)
- stall_id  in  1  ID cannot accept; hold PC, state, IF/ID
- redirect_valid  in  1  later stage corrects PC (mispredicted branch, JR/JALR target, exception)
- redirect_pc  in  16  corrected PC
- ifid_instr  out  16  registered instruction to ID
- ifid_pc_plus2  out  16  registered PC+2 of that instruction (link value, branch base)
- ifid_valid  out  1  IF/ID holds a real instruction
- halted  out  1  fetch stopped on HALT

## Operation
- pc_plus2 = pc_q + 2, modulo 2^16 (0xFFFE wraps to 0x0000).
- jump_tgt = pc_plus2 + sign_extend(imem_rdata[10:0]), modulo 2^16.
- Every PC write forces bit 0 to 0.
- States: RUN, WAIT_JR, HALTED. Reset -> RUN.
- Per-edge priority: redirect_valid > stall_id > state action.
- redirect_valid=1 (any state, regardless of stall_id): pc_q <= redirect_pc; ifid_valid <= 0, ifid_instr <= NOP_INSTR; state <= RUN.
- else stall_id=1: pc_q, state, all ifid_* hold.
- else RUN: ifid_instr <= imem_rdata, ifid_pc_plus2 <= pc_plus2, ifid_valid <= 1; then
  - opcode 00000 (HALT): pc_q holds, state <= HALTED.
  - Jump=1, jmp_r=0: pc_q <= jump_tgt.
  - Jump=1, jmp_r=1: pc_q <= pc_plus2, state <= WAIT_JR.
  - otherwise (incl. Branch=1): pc_q <= pc_plus2.
- else WAIT_JR or HALTED: pc_q holds; ifid_valid <= 0, ifid_instr <= NOP_INSTR; ifid_pc_plus2 holds. Exit only via redirect or reset.
- halted = (state == HALTED), registered.
- Undefined opcodes with all decoder inputs 0 advance as sequential instructions.

## Timing
- Reset values (asserted asynchronously, no edge needed): pc_q=RESET_PC, imem_addr=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus2=16'h0000, ifid_valid=0, halted=0, state RUN.
- First valid IF/ID entry one edge after rst deasserts.
- Fetch throughput: one instruction per cycle in RUN without stall.
- J/JAL: target fetched the cycle after the jump enters IF/ID; zero bubbles.
- JR/JALR: instruction enters IF/ID, then one bubble per cycle until redirect; redirect_pc fetched the cycle after redirect_valid sampled.
- HALT: enters IF/ID with ifid_valid=1 on same edge halted rises.
- Redirect latency: redirect_valid at edge N -> imem_addr=redirect_pc after N, ifid_valid=0 after N.
- Reset mid-operation (any state): immediate return to reset values; pending WAIT_JR/HALTED discarded.

## Test plan
- Sequential: reset, imem returns 0x0800 everywhere -> imem_addr 0x0000,0x0002,0x0004; ifid_pc_plus2 0x0002,0x0004,0x0006; ifid_valid=1 from first edge.
- J at 0x0010, imem_rdata 0x200A (disp +10) -> ifid_instr=0x200A, ifid_pc_plus2=0x0012, next imem_addr=0x001C; same with disp 11'h7FE -> 0x0010. Wrap: NOP at 0xFFFE -> next 0x0000.
- JALR at 0x0020 -> valid once, then 3 cycles ifid_valid=0/ifid_instr=0x0800, imem_addr=0x0022; redirect_valid with 0x0101 -> imem_addr=0x0100, ifid_valid=1 next cycle.
- HALT at 0x0030 -> ifid_instr=0x0000 valid, halted=1, imem_addr stays 0x0030; redirect 0x0040 -> halted=0, fetch resumes at 0x0040.
- stall_id=1 for 2 cycles -> all outputs held; stall_id=1 with redirect_valid=1 -> redirect wins, ifid_valid=0; BEQZ (Branch=1) -> pc_plus2 fetched.
- rst pulsed mid-cycle in WAIT_JR -> immediately imem_addr=RESET_PC, ifid_valid=0, ifid_instr=0x0800; normal fetch after release.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, selects next PC from the IF decoder
// outputs, and holds the IF/ID pipeline register (jumps resolve here, JR/JALR wait).
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    output logic [4:0]  fetch_opcode,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        jmp_r,
    input  logic        stall_id,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_WAIT_JR = 2'b01,
        ST_HALTED  = 2'b10
    } state_t;

    localparam logic [4:0] OPC_HALT = 5'b00000;

    function automatic logic [15:0] sign_ext11(input logic [10:0] disp);
        return {{5{disp[10]}}, disp};
    endfunction

    function automatic logic [15:0] half_align(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

    state_t      state_r;
    logic [15:0] pc_r;
    logic [15:0] ifid_instr_r;
    logic [15:0] ifid_pc_plus2_r;
    logic        ifid_valid_r;
    logic        halted_r;

    logic [15:0] pc_plus2_s;
    logic [15:0] jump_tgt_s;
    logic        is_halt_s;
    logic [15:0] run_pc_s;
    state_t      run_state_s;

    assign pc_plus2_s    = pc_r + 16'd2;
    assign jump_tgt_s    = pc_plus2_s + sign_ext11(imem_rdata[10:0]);
    assign is_halt_s     = (imem_rdata[15:11] == OPC_HALT);

    assign imem_addr     = pc_r;
    assign fetch_opcode  = imem_rdata[15:11];
    assign ifid_instr    = ifid_instr_r;
    assign ifid_pc_plus2 = ifid_pc_plus2_r;
    assign ifid_valid    = ifid_valid_r;
    assign halted        = halted_r;

    // Next PC and state when RUN accepts the instruction currently on imem_rdata.
    always_comb begin
        run_pc_s    = pc_plus2_s;
        run_state_s = ST_RUN;
        if (is_halt_s) begin
            run_pc_s    = pc_r;
            run_state_s = ST_HALTED;
        end else if (Jump && !jmp_r) begin
            run_pc_s    = jump_tgt_s;
            run_state_s = ST_RUN;
        end else if (Jump && jmp_r) begin
            // Target comes from a later stage; park until it redirects us.
            run_pc_s    = pc_plus2_s;
            run_state_s = ST_WAIT_JR;
        end else if (Branch) begin
            // Predicted not-taken; a mispredict arrives later as a redirect.
            run_pc_s    = pc_plus2_s;
            run_state_s = ST_RUN;
        end else begin
            run_pc_s    = pc_plus2_s;
            run_state_s = ST_RUN;
        end
    end

    // PC, fetch state and IF/ID register; redirect beats stall beats normal fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r            <= RESET_PC;
            state_r         <= ST_RUN;
            ifid_instr_r    <= NOP_INSTR;
            ifid_pc_plus2_r <= 16'h0000;
            ifid_valid_r    <= 1'b0;
            halted_r        <= 1'b0;
        end else if (redirect_valid) begin
            pc_r         <= half_align(redirect_pc);
            state_r      <= ST_RUN;
            ifid_instr_r <= NOP_INSTR;
            ifid_valid_r <= 1'b0;
            halted_r     <= 1'b0;
        end else if (stall_id) begin
            pc_r            <= pc_r;
            state_r         <= state_r;
            ifid_instr_r    <= ifid_instr_r;
            ifid_pc_plus2_r <= ifid_pc_plus2_r;
            ifid_valid_r    <= ifid_valid_r;
            halted_r        <= halted_r;
        end else begin
            case (state_r)
                ST_RUN: begin
                    ifid_instr_r    <= imem_rdata;
                    ifid_pc_plus2_r <= pc_plus2_s;
                    ifid_valid_r    <= 1'b1;
                    pc_r            <= half_align(run_pc_s);
                    state_r         <= run_state_s;
                    halted_r        <= (run_state_s == ST_HALTED);
                end
                ST_WAIT_JR, ST_HALTED: begin
                    ifid_instr_r <= NOP_INSTR;
                    ifid_valid_r <= 1'b0;
                end
                default: begin
                    state_r      <= ST_RUN;
                    halted_r     <= 1'b0;
                    ifid_instr_r <= NOP_INSTR;
                    ifid_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: each vector drives one cycle of inputs and
// queues the outputs expected during that cycle; a negedge monitor compares them.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [4:0]  fetch_opcode;
    logic        Jump;
    logic        Branch;
    logic        jmp_r;
    logic        stall_id;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        halted;

    int n_checks;
    int n_fails;

    typedef struct {
        int          idx;
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] pp2;
        logic        valid;
        logic        halt;
        logic [4:0]  opc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   vec_idx;

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .fetch_opcode   (fetch_opcode),
        .Jump           (Jump),
        .Branch         (Branch),
        .jmp_r          (jmp_r),
        .stall_id       (stall_id),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_instr     (ifid_instr),
        .ifid_pc_plus2  (ifid_pc_plus2),
        .ifid_valid     (ifid_valid),
        .halted         (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] want);
        n_checks = n_checks + 1;
        if (act !== want) begin
            n_fails = n_fails + 1;
            $display("FAIL vec%0d %s: got %h expected %h", idx, nm, act, want);
        end
    endtask

    // Monitor: compare queued expectations against the DUT mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("imem_addr",     cur.idx, imem_addr, cur.addr);
            chk("ifid_instr",    cur.idx, ifid_instr, cur.instr);
            chk("ifid_pc_plus2", cur.idx, ifid_pc_plus2, cur.pp2);
            chk("ifid_valid",    cur.idx, {15'd0, ifid_valid}, {15'd0, cur.valid});
            chk("halted",        cur.idx, {15'd0, halted}, {15'd0, cur.halt});
            chk("fetch_opcode",  cur.idx, {11'd0, fetch_opcode}, {11'd0, cur.opc});
        end
    end

    // One cycle: drive inputs just after the edge, queue the outputs expected now.
    task automatic cyc(input logic r, input logic [15:0] rd, input logic j, input logic b,
                       input logic jr, input logic st, input logic rv, input logic [15:0] rpc,
                       input logic [15:0] ea, input logic [15:0] ei, input logic [15:0] ep,
                       input logic ev, input logic eh);
        exp_t e;
        rst            = r;
        imem_rdata     = rd;
        Jump           = j;
        Branch         = b;
        jmp_r          = jr;
        stall_id       = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        e.idx   = vec_idx;
        e.addr  = ea;
        e.instr = ei;
        e.pp2   = ep;
        e.valid = ev;
        e.halt  = eh;
        e.opc   = rd[15:11];
        exp_q.push_back(e);
        vec_idx = vec_idx + 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        vec_idx  = 1;
        rst = 1'b1; imem_rdata = 16'h0800; Jump = 1'b0; Branch = 1'b0; jmp_r = 1'b0;
        stall_id = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        @(posedge clk);
        #1;
        //   rst   rdata     J     B     JR    st    rv    rpc       addr      instr     pp2       v     h
        // reset and sequential fetch
        cyc(1'b1, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'h0800, 16'h0002, 1'b1, 1'b0);
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h0800, 16'h0004, 1'b1, 1'b0);
        // J +10 at 0x0010
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0006, 16'h0800, 16'h0006, 1'b1, 1'b0);
        cyc(1'b0, 16'h200A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0800, 16'h0006, 1'b0, 1'b0);
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h001C, 16'h200A, 16'h0012, 1'b1, 1'b0);
        // J -2 at 0x0010 loops to itself
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h001E, 16'h0800, 16'h001E, 1'b1, 1'b0);
        cyc(1'b0, 16'h27FE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0800, 16'h001E, 1'b0, 1'b0);
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h27FE, 16'h0012, 1'b1, 1'b0);
        // PC wrap at 0xFFFE
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 16'h0012, 16'h0800, 16'h0012, 1'b1, 1'b0);
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFE, 16'h0800, 16'h0012, 1'b0, 1'b0);
        // odd redirect target is forced even; JALR at 0x0020 waits for redirect
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0021, 16'h0000, 16'h0800, 16'h0000, 1'b1, 1'b0);
        cyc(1'b0, 16'h4800, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0020, 16'h0800, 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0022, 16'h4800, 16'h0022, 1'b1, 1'b0);
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0022, 16'h0800, 16'h0022, 1'b0, 1'b0);
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0022, 16'h0800, 16'h0022, 1'b0, 1'b0);
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0101, 16'h0022, 16'h0800, 16'h0022, 1'b0, 1'b0);
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0100, 16'h0800, 16'h0022, 1'b0, 1'b0);
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0102, 16'h0800, 16'h0102, 1'b1, 1'b0);
        // HALT at 0x0030, released by redirect to 0x0040
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0030, 16'h0104, 16'h0800, 16'h0104, 1'b1, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0030, 16'h0800, 16'h0104, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0030, 16'h0000, 16'h0032, 1'b1, 1'b1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0040, 16'h0030, 16'h0800, 16'h0032, 1'b0, 1'b1);
        // undefined opcode advances; stall holds two cycles; redirect overrides stall
        cyc(1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0040, 16'h0800, 16'h0032, 1'b0, 1'b0);
        cyc(1'b0, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0042, 16'h1234, 16'h0042, 1'b1, 1'b0);
        cyc(1'b0, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0042, 16'h1234, 16'h0042, 1'b1, 1'b0);
        cyc(1'b0, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0050, 16'h0042, 16'h1234, 16'h0042, 1'b1, 1'b0);
        // BEQZ predicted not-taken
        cyc(1'b0, 16'h8806, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0050, 16'h0800, 16'h0042, 1'b0, 1'b0);
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0052, 16'h8806, 16'h0052, 1'b1, 1'b0);
        // JR at 0x0054, then asynchronous reset while waiting
        cyc(1'b0, 16'h4000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0054, 16'h0800, 16'h0054, 1'b1, 1'b0);
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0056, 16'h4000, 16'h0056, 1'b1, 1'b0);
        cyc(1'b1, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'h0800, 16'h0002, 1'b1, 1'b0);
        cyc(1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h0800, 16'h0004, 1'b1, 1'b0);

        for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        n_checks = n_checks + 1;
        if (exp_q.size() != 0) begin
            n_fails = n_fails + 1;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
